// File: rtl/send_buff_if.sv
// Core-side push port and router-side valid/ready link of the send buffer.
// credit_ret is part of the buffer's modport only when SEND_BUFF_CREDIT_EN is defined.
interface send_buff_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 8,
    parameter int DEST_WIDTH = 4,
    parameter int NUM_ENTRY  = 8
);
    localparam int CNT_W = $clog2(NUM_ENTRY) + 1;
    localparam int PKT_W = DEST_WIDTH + TAG_WIDTH + DATA_WIDTH;

    logic                  wen;
    logic [DATA_WIDTH-1:0] data_in;
    logic [TAG_WIDTH-1:0]  tag_in;
    logic [DEST_WIDTH-1:0] dest_in;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  err_ovf;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [PKT_W-1:0]      tx_pkt;
    logic                  credit_ret;

    modport master (
`ifdef SEND_BUFF_CREDIT_EN
        output credit_ret,
`endif
        output wen, data_in, tag_in, dest_in, tx_ready,
        input  full, empty, count, err_ovf, tx_valid, tx_pkt
    );

    modport slave (
`ifdef SEND_BUFF_CREDIT_EN
        input  credit_ret,
`endif
        input  wen, data_in, tag_in, dest_in, tx_ready,
        output full, empty, count, err_ovf, tx_valid, tx_pkt
    );
endinterface

// File: rtl/send_buff.sv
// Tile transmit FIFO: core pushes {dest, tag, data}, drained in order over valid/ready.
// Optional credit-based flow control is enabled with the SEND_BUFF_CREDIT_EN macro.
module send_buff #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 8,
    parameter int DEST_WIDTH = 4,
    parameter int NUM_ENTRY  = 8,
    parameter int CREDITS    = 4
) (
    input logic         CLK,
    input logic         nRST,
    send_buff_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_ENTRY);
    localparam int CNT_W = PTR_W + 1;
    localparam int PKT_W = DEST_WIDTH + TAG_WIDTH + DATA_WIDTH;

    logic [PKT_W-1:0] mem_r [NUM_ENTRY];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             tx_valid_r;
    logic             tx_valid_nxt_s;
    logic             err_ovf_r;
    logic             push_s;
    logic             fire_s;
    logic [PKT_W-1:0] tx_pkt_s;

`ifdef SEND_BUFF_CREDIT_EN
    localparam int CRD_W = $clog2(CREDITS) + 1;
    logic [CRD_W-1:0] credits_r;
    logic [CRD_W-1:0] credits_nxt_s;
`endif

    // Handshake decode and next occupancy; full is taken from the pre-edge count
    always_comb begin
        push_s      = bus.wen && !full_r;
        fire_s      = tx_valid_r && bus.tx_ready;
        count_nxt_s = count_r;
        case ({push_s, fire_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

`ifdef SEND_BUFF_CREDIT_EN
    // Credit bookkeeping: a returned credit at the ceiling is discarded
    always_comb begin
        credits_nxt_s = credits_r;
        case ({fire_s, bus.credit_ret})
            2'b10: credits_nxt_s = credits_r - CRD_W'(1);
            2'b01: begin
                if (credits_r == CRD_W'(CREDITS)) begin
                    credits_nxt_s = credits_r;
                end else begin
                    credits_nxt_s = credits_r + CRD_W'(1);
                end
            end
            default: credits_nxt_s = credits_r;
        endcase
        tx_valid_nxt_s = (count_nxt_s != CNT_W'(0)) && (credits_nxt_s != CRD_W'(0));
    end
`else
    // Offer the head whenever anything is queued
    always_comb begin
        tx_valid_nxt_s = (count_nxt_s != CNT_W'(0));
    end
`endif

    // Control state; status flags are registered alongside count so they never glitch
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_r   <= PTR_W'(0);
            rd_ptr_r   <= PTR_W'(0);
            count_r    <= CNT_W'(0);
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            tx_valid_r <= 1'b0;
            err_ovf_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (bus.wen && full_r) begin
                err_ovf_r <= 1'b1;
            end
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == CNT_W'(NUM_ENTRY));
            empty_r    <= (count_nxt_s == CNT_W'(0));
            tx_valid_r <= tx_valid_nxt_s;
        end
    end

`ifdef SEND_BUFF_CREDIT_EN
    // Credit counter starts full
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            credits_r <= CRD_W'(CREDITS);
        end else begin
            credits_r <= credits_nxt_s;
        end
    end
`endif

    // Entry storage is deliberately not reset
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.dest_in, bus.tag_in, bus.data_in};
        end
    end

    // Head entry is forced to zero whenever it is not being offered
    always_comb begin
        if (tx_valid_r) begin
            tx_pkt_s = mem_r[rd_ptr_r];
        end else begin
            tx_pkt_s = PKT_W'(0);
        end
    end

    assign bus.tx_pkt   = tx_pkt_s;
    assign bus.tx_valid = tx_valid_r;
    assign bus.count    = count_r;
    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.err_ovf  = err_ovf_r;
endmodule

// File: tb/tb_send_buff.sv
// Self-checking bench for send_buff: directed vector table, corner sequences, and a
// randomized run against a queue-based reference model (credit tests under SEND_BUFF_CREDIT_EN).
module tb_send_buff;
    localparam int NE = 8;
    localparam int CR = 4;

    typedef struct {
        logic        wen;
        logic        rdy;
        logic [19:0] pkt_in;
        int          exp_count;
        logic        exp_valid;
        logic        exp_full;
        logic        exp_ovf;
        logic [19:0] exp_pkt;
    } vec_t;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_fail;
    vec_t vecs [$];

`ifdef SEND_BUFF_CREDIT_EN
    localparam logic CRET_IDLE = 1'b1;
`else
    localparam logic CRET_IDLE = 1'b0;
`endif

    send_buff_if #(.DATA_WIDTH(8), .TAG_WIDTH(8), .DEST_WIDTH(4), .NUM_ENTRY(NE)) bus ();

    send_buff #(.DATA_WIDTH(8), .TAG_WIDTH(8), .DEST_WIDTH(4), .NUM_ENTRY(NE), .CREDITS(CR)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [19:0] ent(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b[3:0], b, ~b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [19:0] p);
        bus.wen      = w;
        bus.tx_ready = r;
        bus.dest_in  = p[19:16];
        bus.tag_in   = p[15:8];
        bus.data_in  = p[7:0];
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string nm, input int c, input logic v, input logic f,
                             input logic o, input logic [19:0] p);
        chk({nm, ".count"}, 32'(bus.count), 32'(c));
        chk({nm, ".valid"}, 32'(bus.tx_valid), 32'(v));
        chk({nm, ".full"}, 32'(bus.full), 32'(f));
        chk({nm, ".empty"}, 32'(bus.empty), 32'(c == 0));
        chk({nm, ".ovf"}, 32'(bus.err_ovf), 32'(o));
        chk({nm, ".pkt"}, 32'(bus.tx_pkt), 32'(p));
    endtask

    task automatic do_reset(input logic check_it);
        nRST           = 1'b0;
        bus.credit_ret = CRET_IDLE;
        drive(1'b0, 1'b0, 20'h0);
        repeat (2) @(posedge CLK);
        #1;
        if (check_it) chk_state("reset", 0, 1'b0, 1'b0, 1'b0, 20'h0);
        nRST = 1'b1;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, ent(base + i));
            step();
        end
        drive(1'b0, 1'b0, 20'h0);
    endtask

    // Queue-based reference model for the random run
    logic [19:0] mq [$];
    logic        m_ovf;
    int          m_cred;

    function automatic logic m_valid();
`ifdef SEND_BUFF_CREDIT_EN
        return (mq.size() > 0) && (m_cred > 0);
`else
        return (mq.size() > 0);
`endif
    endfunction

    initial begin
        int   fires;
        logic w, r, c, fire;
        logic [19:0] p;
        n_checks = 0;
        n_fail   = 0;

        // Directed table: first push, fill past full, in-order drain
        vecs.push_back('{1'b1, 1'b0, 20'h312A5, 1, 1'b1, 1'b0, 1'b0, 20'h312A5});
        vecs.push_back('{1'b0, 1'b1, 20'h0,     0, 1'b0, 1'b0, 1'b0, 20'h0});
        for (int i = 0; i < NE; i++)
            vecs.push_back('{1'b1, 1'b0, ent(i), i + 1, 1'b1, (i == NE - 1), 1'b0, ent(0)});
        vecs.push_back('{1'b1, 1'b0, ent(8), NE, 1'b1, 1'b1, 1'b1, ent(0)});
        for (int i = 0; i < NE; i++)
            vecs.push_back('{1'b0, 1'b1, 20'h0, NE - 1 - i, (i < NE - 1), 1'b0, 1'b1,
                             (i < NE - 1) ? ent(i + 1) : 20'h0});

        do_reset(1'b1);
        foreach (vecs[k]) begin
            drive(vecs[k].wen, vecs[k].rdy, vecs[k].pkt_in);
            step();
            chk_state($sformatf("vec%0d", k), vecs[k].exp_count, vecs[k].exp_valid,
                      vecs[k].exp_full, vecs[k].exp_ovf, vecs[k].exp_pkt);
        end

        // Backpressure: 3 queued, ready pattern 1,0,0,1
        do_reset(1'b0);
        push_n(3, 0);
        drive(1'b0, 1'b1, 20'h0); step(); chk_state("bp0", 2, 1'b1, 1'b0, 1'b0, ent(1));
        drive(1'b0, 1'b0, 20'h0); step(); chk_state("bp1", 2, 1'b1, 1'b0, 1'b0, ent(1));
        drive(1'b0, 1'b0, 20'h0); step(); chk_state("bp2", 2, 1'b1, 1'b0, 1'b0, ent(1));
        drive(1'b0, 1'b1, 20'h0); step(); chk_state("bp3", 1, 1'b1, 1'b0, 1'b0, ent(2));

        // Streaming: push and ready every cycle for 20 cycles, pointers wrap
        do_reset(1'b0);
        fires = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, ent(32 + i));
            if (bus.tx_valid) fires++;
            step();
            chk("stream.count", 32'(bus.count), 32'd1);
            chk("stream.pkt", 32'(bus.tx_pkt), 32'(ent(32 + i)));
        end
        drive(1'b0, 1'b0, 20'h0);
        chk("stream.fires", 32'(fires), 32'd19);
        chk("stream.ovf", 32'(bus.err_ovf), 32'd0);

        // Full with simultaneous pop: push dropped, pop happens
        do_reset(1'b0);
        push_n(NE, 0);
        drive(1'b1, 1'b1, ent(99)); step();
        drive(1'b0, 1'b0, 20'h0);
        chk_state("fullpop", NE - 1, 1'b1, 1'b0, 1'b1, ent(1));

        // Asynchronous reset with 5 queued, checked before any clock edge
        do_reset(1'b0);
        push_n(5, 0);
        chk("mid.valid_pre", 32'(bus.tx_valid), 32'd1);
        #2 nRST = 1'b0;
        #1 chk_state("async_rst", 0, 1'b0, 1'b0, 1'b0, 20'h0);
        do_reset(1'b0);

`ifdef SEND_BUFF_CREDIT_EN
        // Credits: 6 queued, only 4 fire, one returned credit allows one more
        bus.credit_ret = 1'b0;
        push_n(6, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 20'h0); step();
            chk("crd.count", 32'(bus.count), 32'(5 - i));
        end
        chk("crd.stall_valid", 32'(bus.tx_valid), 32'd0);
        step();
        chk("crd.stall_count", 32'(bus.count), 32'd2);
        bus.credit_ret = 1'b1; step();
        bus.credit_ret = 1'b0;
        chk_state("crd.ret", 2, 1'b1, 1'b0, 1'b0, ent(4));
        step();
        chk_state("crd.fire", 1, 1'b0, 1'b0, 1'b0, 20'h0);
`endif

        // Randomized run against the reference model
        do_reset(1'b0);
        mq.delete();
        m_ovf  = 1'b0;
        m_cred = CR;
        for (int i = 0; i < 400; i++) begin
            chk("rnd.count", 32'(bus.count), 32'(mq.size()));
            chk("rnd.valid", 32'(bus.tx_valid), 32'(m_valid()));
            chk("rnd.pkt", 32'(bus.tx_pkt), 32'(m_valid() ? mq[0] : 20'h0));
            chk("rnd.full", 32'(bus.full), 32'(mq.size() == NE));
            chk("rnd.ovf", 32'(bus.err_ovf), 32'(m_ovf));
            w = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 5);
            c = ($urandom_range(0, 9) < 3);
            p = 20'($urandom);
            drive(w, r, p);
            bus.credit_ret = c;
            fire = m_valid() && r;
            if (w && mq.size() == NE) m_ovf = 1'b1;
            if (fire) void'(mq.pop_front());
            if (w && (mq.size() + (fire ? 1 : 0)) < NE + (fire ? 1 : 0) && !(mq.size() == NE && !fire)
                && !(fire && mq.size() + 1 == NE))
                mq.push_back(p);
            if (fire && !c) m_cred--;
            else if (!fire && c && m_cred < CR) m_cred++;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
